// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - UART receive FIFO host-side signal bundle
interface uart_rx_fifo_if #(
  parameter int AW = 3
);
  logic          uart_rx;
  logic          rd_en;
  logic          err_clr;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW:0]   rx_count;
  logic          frame_err;
  logic          overrun;

  modport master (
    output uart_rx, rd_en, err_clr,
    input  rx_data, rx_valid, rx_count, frame_err, overrun
  );

  modport slave (
    input  uart_rx, rd_en, err_clr,
    output rx_data, rx_valid, rx_count, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled 8N1 UART receiver feeding a FWFT byte FIFO
module uart_rx_fifo #(
  parameter int BAUD_DIV = 651,
  parameter int DEPTH    = 8,
  parameter int AW       = 3
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [15:0] TICK_MAX = 16'(BAUD_DIV - 1);
  localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW + 1)'(1);

  logic          rx_meta;
  logic          rx_s;
  logic [15:0]   div_cnt;
  logic          tick;
  state_t        state;
  logic [3:0]    scnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          push_q;
  logic          frame_err_q;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overrun_q;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (div_cnt == TICK_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= 16'd0;
    end else if (tick) begin
      div_cnt <= 16'd0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // push_q is a one-cycle strobe so the FIFO write lands one clk after the stop sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      scnt        <= 4'd0;
      bit_idx     <= 3'd0;
      shift_q     <= 8'h00;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (bus.err_clr) frame_err_q <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              scnt  <= 4'd0;
            end
          end
          START: begin
            if (scnt == 4'd7) begin
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= 3'd0;
                scnt    <= 4'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              scnt <= scnt + 4'd1;
            end
          end
          DATA: begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'd15) begin
              shift_q <= {rx_s, shift_q[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end
          end
          STOP: begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'd15) begin
              if (rx_s) begin
                push_q <= 1'b1;
                state  <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state       <= BREAK;
              end
            end
          end
          BREAK: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A full FIFO still accepts a push when the same cycle pops its head
  assign do_pop  = bus.rd_en && (count != '0);
  assign do_push = push_q && ((count != FULL) || bus.rd_en);
  assign drop    = push_q && (count == FULL) && !bus.rd_en;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (bus.err_clr) overrun_q <= 1'b0;
      if (drop)        overrun_q <= 1'b1;
    end
  end

  assign bus.rx_data   = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign bus.rx_valid  = (count != '0);
  assign bus.rx_count  = count;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Hardware UART receive front-end that sits directly upstream of the peripheral register block.
- Oversamples the serial line at 16x baud, deserialises 8N1 frames and pushes bytes into a small first-word-fall-through FIFO.
- The peripheral reads the FIFO head as its received-data register and pops one byte per read.
- Software no longer loses bytes that arrive between polls.

Parameters:
- BAUD_DIV, 651, clk cycles per 16x sample tick (100 MHz / 9600 / 16); legal range 2..65535
- DEPTH, 8, FIFO entries; must be a power of two, 2..64
- AW, 3, log2(DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- uart_rx  in  1  raw serial input, idle high, asynchronous to clk
- rd_en  in  1  pop strobe, one byte per cycle when high
- rx_data  out  8  FIFO head byte, valid when rx_valid=1
- rx_valid  out  1  FIFO non-empty
- rx_count  out  AW+1  number of bytes held, 0..DEPTH
- frame_err  out  1  sticky flag: stop bit sampled low
- overrun  out  1  sticky flag: byte dropped because FIFO was full
- err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (asynchronous, active-high) values:
  - Outputs: rx_data=0, rx_valid=0, rx_count=0, frame_err=0, overrun=0.
  - Internal: synchroniser FFs=1, FSM=IDLE, tick counter=0, FIFO pointers=0.
  - Reset mid-frame abandons the frame; no partial byte is pushed.
- Input synchroniser: two flip-flops on uart_rx; all logic uses the second stage (rx_s).
- Tick generator:
  - Free-running counter 0..BAUD_DIV-1.
  - tick=1 for one clk when the counter equals BAUD_DIV-1, then wraps to 0.
- Sample counter: scnt, 4 bits, advances on tick only; cleared on entry to START.
- IDLE: rx_s=0 sampled on a tick -> START, scnt=0.
- START:
  - On the tick where scnt=7 (start-bit centre): rx_s=0 -> DATA with bit index 0 and scnt reset to 0.
  - rx_s=1 -> IDLE (glitch rejected; no flag set).
- DATA:
  - On each tick where scnt=15, shift rx_s into the shift register, LSB first.
  - After bit 7 -> STOP.
- STOP, on the tick where scnt=15:
  - rx_s=1: push the byte; next state IDLE.
  - rx_s=0: set frame_err, discard the byte; next state BREAK.
- BREAK: stays until rx_s=1 is sampled on a tick, then -> IDLE. No start detection while in BREAK.
- Push timing:
  - The FIFO write occurs on the clk edge following the stop-bit sample tick.
  - rx_valid and rx_count update on that same edge.
  - Serial-to-visible latency is 1 clk after the stop-bit sample.
- FIFO (first-word-fall-through):
  - rx_data is combinationally the head entry. When empty it is 0, not a stale value.
  - Pointers are AW bits and wrap modulo DEPTH; rx_count is tracked separately.
  - rd_en with rx_count=0: ignored, no pointer change.
  - push with rx_count=DEPTH and rd_en=0: byte dropped, overrun set, contents unchanged.
  - push with rx_count=DEPTH and rd_en=1: pop and push both occur, rx_count stays DEPTH, no overrun.
  - push and rd_en together with 0<rx_count<DEPTH: both occur, rx_count unchanged.
  - push with rx_count=0 and rd_en=1: pop ignored, push accepted, rx_count becomes 1.
- Sticky flags:
  - err_clr clears frame_err and overrun on the next edge.
  - If a set event coincides with err_clr, set wins (flag stays 1).
- Timing: one frame = 10 bits x 16 ticks x BAUD_DIV clk; back-to-back frames are supported with no idle gap.

Test Plan (bench uses BAUD_DIV=4, DEPTH=8, 64 clk per bit):
- Single frame: send 0xA5 with stop=1 -> exactly one push. rx_valid rises; rx_count=1; rx_data=0xA5. Pulse rd_en for 1 clk -> rx_valid=0, rx_data=0, rx_count=0.
- Glitch rejection: drive uart_rx low for 20 clk, then high -> FSM returns to IDLE. No push, no flags set.
- Back-to-back stream: send 0x00, 0xFF, 0x55 with no gaps -> rx_count=3. Pops return 0x00, 0xFF, 0x55 in order.
- Overrun and pointer wrap:
  - Send 9 bytes 0x01..0x09 with no pops -> rx_count=8, overrun=1. Pops return 0x01..0x08.
  - Then send 0x0A -> rx_data=0x0A, exercising wrap-around.
  - Repeat with rd_en asserted on the 9th push cycle -> overrun stays 0 and rx_count stays 8.
- Framing error and break:
  - Send 0x3C with stop bit low, then hold the line low for 200 clk -> frame_err=1, rx_count=0, no start detected during the low period.
  - Line high, then send 0x3C correctly -> push of 0x3C.
  - err_clr pulse -> frame_err=0.
  - err_clr asserted on the same cycle as a new framing error -> frame_err stays 1.
- Reset mid-frame: assert reset during data bit 4 -> all outputs 0 immediately, asynchronously. After release, a clean 0x81 frame is received correctly.
